// File: rtl/dcache_miss_controller.sv
// rtl/dcache_miss_controller.sv - MEM-stage data cache miss/refill and write-through sequencer
module dcache_miss_controller #(
    parameter int BLOCK_WORDS = 4,
    parameter int IDX_W       = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             cache_en,
    input  logic             mem_write,
    input  logic             is_LB_SB,
    input  logic [31:0]      addr,
    input  logic             hit,
    input  logic             mem_ready,
    output logic             freeze,
    output logic             mem_rd_req,
    output logic             mem_wr_req,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_byte_en,
    output logic             fill_we,
    output logic [IDX_W-1:0] fill_word,
    output logic             tag_we,
    output logic             cache_wr_hit_we,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        RESUME
    } state_t;

    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(BLOCK_WORDS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] fill_word_q, fill_word_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            fill_word_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            fill_word_q  <= fill_word_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        fill_word_d     = fill_word_q;
        miss_count_d    = miss_count_q;
        freeze          = 1'b0;
        mem_rd_req      = 1'b0;
        mem_wr_req      = 1'b0;
        mem_addr        = '0;
        mem_byte_en     = '0;
        fill_we         = 1'b0;
        fill_word       = '0;
        tag_we          = 1'b0;
        cache_wr_hit_we = 1'b0;

        case (state_q)
            IDLE: begin
                if (cache_en) begin
                    if (mem_write) begin
                        freeze          = 1'b1;
                        cache_wr_hit_we = hit;
                        state_d         = WRITE;
                    end else if (!hit) begin
                        freeze      = 1'b1;
                        fill_word_d = '0;
                        state_d     = REFILL;
                        if (miss_count_q != '1) begin
                            miss_count_d = miss_count_q + CNT_W'(1);
                        end
                    end
                end
            end
            REFILL: begin
                freeze     = 1'b1;
                mem_rd_req = 1'b1;
                mem_addr   = {addr[31:IDX_W+2], fill_word_q, 2'b00};
                fill_word  = fill_word_q;
                if (mem_ready) begin
                    fill_we     = 1'b1;
                    fill_word_d = fill_word_q + IDX_W'(1);
                    // Last word of the block: validate the line and let the load retire.
                    if (fill_word_q == LAST_WORD) begin
                        tag_we      = 1'b1;
                        fill_word_d = '0;
                        state_d     = RESUME;
                    end
                end
            end
            WRITE: begin
                freeze      = 1'b1;
                mem_wr_req  = 1'b1;
                mem_addr    = addr;
                mem_byte_en = is_LB_SB ? (4'b0001 << addr[1:0]) : 4'b1111;
                if (mem_ready) begin
                    state_d = RESUME;
                end
            end
            RESUME: begin
                // One unfrozen edge so the stalled instruction leaves MEM before decode resumes.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!rst_b) begin
            freeze          = 1'b0;
            mem_rd_req      = 1'b0;
            mem_wr_req      = 1'b0;
            mem_addr        = '0;
            mem_byte_en     = '0;
            fill_we         = 1'b0;
            fill_word       = '0;
            tag_we          = 1'b0;
            cache_wr_hit_we = 1'b0;
        end
    end

    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dcache_miss_controller.sv
// tb/tb_dcache_miss_controller.sv - directed self-checking bench for dcache_miss_controller
module tb_dcache_miss_controller;

    logic        clk;
    logic        rst_b;
    logic        cache_en;
    logic        mem_write;
    logic        is_LB_SB;
    logic [31:0] addr;
    logic        hit;
    logic        mem_ready;
    logic        freeze;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_en;
    logic        fill_we;
    logic [1:0]  fill_word;
    logic        tag_we;
    logic        cache_wr_hit_we;
    logic [3:0]  miss_count;

    int total;
    int bad;

    dcache_miss_controller #(
        .BLOCK_WORDS(4),
        .IDX_W      (2),
        .CNT_W      (4)
    ) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .cache_en       (cache_en),
        .mem_write      (mem_write),
        .is_LB_SB       (is_LB_SB),
        .addr           (addr),
        .hit            (hit),
        .mem_ready      (mem_ready),
        .freeze         (freeze),
        .mem_rd_req     (mem_rd_req),
        .mem_wr_req     (mem_wr_req),
        .mem_addr       (mem_addr),
        .mem_byte_en    (mem_byte_en),
        .fill_we        (fill_we),
        .fill_word      (fill_word),
        .tag_we         (tag_we),
        .cache_wr_hit_we(cache_wr_hit_we),
        .miss_count     (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_b = 1'b0; cache_en = 1'b1; mem_write = 1'b0; is_LB_SB = 1'b0;
        addr = 32'h1C; hit = 1'b0; mem_ready = 1'b1;
        #1;
        total++;
        if ({freeze, mem_rd_req, mem_wr_req, fill_we, tag_we, cache_wr_hit_we} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {freeze, mem_rd_req, mem_wr_req, fill_we, tag_we, cache_wr_hit_we});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({mem_addr, mem_byte_en, fill_word, miss_count} !== 42'b0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h be=%b fw=%0d mc=%0d want 0", mem_addr, mem_byte_en, fill_word, miss_count);
        end
        total++;
        if (freeze !== 1'b0) begin
            bad++;
            $display("FAIL reset_freeze_held: got %b want 0", freeze);
        end
        cache_en = 1'b0; mem_ready = 1'b0; rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_hit;
        cache_en = 1'b1; mem_write = 1'b0; hit = 1'b1; addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({freeze, mem_rd_req, mem_wr_req} !== 3'b000) begin
                bad++;
                $display("FAIL load_hit_cycle%0d: got frz/rd/wr=%b want 000", i, {freeze, mem_rd_req, mem_wr_req});
            end
            @(negedge clk);
        end
        cache_en = 1'b0; mem_ready = 1'b1;
        #1;
        total++;
        if ({freeze, fill_we, tag_we} !== 3'b000) begin
            bad++;
            $display("FAIL stray_ready: got frz/fill/tag=%b want 000", {freeze, fill_we, tag_we});
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (miss_count !== 4'd0) begin
            bad++;
            $display("FAIL load_hit_count: got %0d want 0", miss_count);
        end
        @(negedge clk);
    endtask

    task automatic test_load_miss;
        logic [31:0] exp_a [4];
        int wc, words, fz, tags;
        bit done;
        exp_a[0] = 32'h10; exp_a[1] = 32'h14; exp_a[2] = 32'h18; exp_a[3] = 32'h1C;
        wc = 0; words = 0; fz = 0; tags = 0; done = 1'b0;
        cache_en = 1'b1; mem_write = 1'b0; is_LB_SB = 1'b0; hit = 1'b0; addr = 32'h1C;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (cyc > 0 && !freeze) begin
                done = 1'b1;
            end else begin
                if (freeze) fz++;
                if (cyc == 0) begin
                    total++;
                    if ({freeze, mem_rd_req} !== 2'b10) begin
                        bad++;
                        $display("FAIL miss_decode: got frz/rd=%b want 10", {freeze, mem_rd_req});
                    end
                end
                if (mem_rd_req && words < 4) begin
                    total++;
                    if (mem_addr !== exp_a[words] || fill_word !== 2'(words)) begin
                        bad++;
                        $display("FAIL refill_addr%0d: got addr=%h fw=%0d want addr=%h fw=%0d",
                                 words, mem_addr, fill_word, exp_a[words], words);
                    end
                    mem_ready = (wc == 1);
                    #1;
                    total++;
                    if (fill_we !== mem_ready || tag_we !== (mem_ready && words == 3)) begin
                        bad++;
                        $display("FAIL refill_we%0d: got fill=%b tag=%b want fill=%b tag=%b",
                                 words, fill_we, tag_we, mem_ready, (mem_ready && words == 3));
                    end
                    if (tag_we) tags++;
                    if (mem_ready) begin
                        words++; wc = 0;
                    end else begin
                        wc++;
                    end
                end
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
        total++;
        if (!done || mem_rd_req !== 1'b0) begin
            bad++;
            $display("FAIL refill_resume: got done=%b rd=%b want done=1 rd=0", done, mem_rd_req);
        end
        total++;
        if (fz != 9 || words != 4 || tags != 1) begin
            bad++;
            $display("FAIL refill_totals: got freeze=%0d words=%0d tags=%0d want 9 4 1", fz, words, tags);
        end
        total++;
        if (miss_count !== 4'd1) begin
            bad++;
            $display("FAIL miss_count_one: got %0d want 1", miss_count);
        end
        hit = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (freeze !== 1'b0) begin
            bad++;
            $display("FAIL refilled_hit: got freeze=%b want 0", freeze);
        end
        cache_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_hit;
        int wc, wr, hwe;
        bit done;
        wc = 0; wr = 0; hwe = 0; done = 1'b0;
        cache_en = 1'b1; mem_write = 1'b1; is_LB_SB = 1'b0; hit = 1'b1; addr = 32'h20;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (cyc > 0 && !freeze) begin
                done = 1'b1;
            end else begin
                if (cache_wr_hit_we) hwe++;
                if (cyc == 0) begin
                    total++;
                    if ({freeze, cache_wr_hit_we, mem_wr_req} !== 3'b110) begin
                        bad++;
                        $display("FAIL sw_decode: got frz/hwe/wr=%b want 110", {freeze, cache_wr_hit_we, mem_wr_req});
                    end
                end
                if (mem_wr_req) begin
                    wr++;
                    total++;
                    if (mem_byte_en !== 4'b1111 || mem_addr !== 32'h20 || mem_rd_req !== 1'b0) begin
                        bad++;
                        $display("FAIL sw_req: got be=%b addr=%h rd=%b want 1111 00000020 0", mem_byte_en, mem_addr, mem_rd_req);
                    end
                    mem_ready = (wc == 2);
                    if (mem_ready) wc = 0; else wc++;
                end
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
        total++;
        if (!done || wr != 3 || hwe != 1 || mem_wr_req !== 1'b0) begin
            bad++;
            $display("FAIL sw_totals: got done=%b wr=%0d hwe=%0d wr_now=%b want 1 3 1 0", done, wr, hwe, mem_wr_req);
        end
        cache_en = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({freeze, mem_wr_req} !== 2'b00) begin
            bad++;
            $display("FAIL sw_idle: got frz/wr=%b want 00", {freeze, mem_wr_req});
        end
        @(negedge clk);
    endtask

    task automatic test_sb_miss;
        int wr, stray;
        bit done;
        wr = 0; stray = 0; done = 1'b0;
        cache_en = 1'b1; mem_write = 1'b1; is_LB_SB = 1'b1; hit = 1'b0; addr = 32'h23;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (cyc > 0 && !freeze) begin
                done = 1'b1;
            end else begin
                if (mem_wr_req) begin
                    wr++;
                    total++;
                    if (mem_byte_en !== 4'b1000 || mem_addr !== 32'h23) begin
                        bad++;
                        $display("FAIL sb_req: got be=%b addr=%h want 1000 00000023", mem_byte_en, mem_addr);
                    end
                    mem_ready = 1'b1;
                    #1;
                end
                if (cache_wr_hit_we || fill_we || tag_we || mem_rd_req) stray++;
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
        total++;
        if (!done || wr != 1 || stray != 0) begin
            bad++;
            $display("FAIL sb_totals: got done=%b wr=%0d stray=%0d want 1 1 0", done, wr, stray);
        end
        total++;
        if (miss_count !== 4'd1) begin
            bad++;
            $display("FAIL sb_count: got %0d want 1", miss_count);
        end
        cache_en = 1'b0; mem_write = 1'b0; is_LB_SB = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_refill;
        int wc, words;
        wc = 0; words = 0;
        cache_en = 1'b1; mem_write = 1'b0; hit = 1'b0; addr = 32'h1C;
        for (int cyc = 0; cyc < 40 && words < 2; cyc++) begin
            #1;
            if (mem_rd_req) begin
                mem_ready = (wc == 1);
                if (mem_ready) begin
                    words++; wc = 0;
                end else begin
                    wc++;
                end
            end
            @(negedge clk);
            mem_ready = 1'b0;
        end
        #1;
        total++;
        if (words != 2 || fill_word !== 2'd2 || mem_rd_req !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: got words=%0d fw=%0d rd=%b want 2 2 1", words, fill_word, mem_rd_req);
        end
        rst_b = 1'b0;
        #1;
        total++;
        if ({freeze, mem_rd_req, mem_wr_req, fill_we, tag_we, cache_wr_hit_we, mem_addr, mem_byte_en, fill_word, miss_count} !== 48'b0) begin
            bad++;
            $display("FAIL async_reset: got frz=%b rd=%b addr=%h fw=%0d mc=%0d want 0",
                     freeze, mem_rd_req, mem_addr, fill_word, miss_count);
        end
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({fill_we, tag_we} !== 2'b00) begin
            bad++;
            $display("FAIL reset_no_fill: got fill/tag=%b want 00", {fill_we, tag_we});
        end
        @(negedge clk);
        mem_ready = 1'b0; hit = 1'b1; addr = 32'h40; rst_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if ({freeze, mem_rd_req, fill_word} !== 4'b0) begin
                bad++;
                $display("FAIL post_reset_hit%0d: got frz=%b rd=%b fw=%0d want 0 0 0", i, freeze, mem_rd_req, fill_word);
            end
            @(negedge clk);
        end
        cache_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_miss(input logic [31:0] a);
        bit done;
        done = 1'b0;
        cache_en = 1'b1; mem_write = 1'b0; hit = 1'b0; addr = a;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            #1;
            if (cyc > 0 && !freeze) begin
                done = 1'b1;
            end else begin
                mem_ready = mem_rd_req;
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
        cache_en = 1'b0;
        @(negedge clk);
        total++;
        if (!done) begin
            bad++;
            $display("FAIL miss_timeout: addr=%h got no resume want resume", a);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 14; i++) do_miss(32'h100 + 32'(i * 16));
        total++;
        if (miss_count !== 4'd14) begin
            bad++;
            $display("FAIL count_14: got %0d want 14", miss_count);
        end
        do_miss(32'h200);
        total++;
        if (miss_count !== 4'd15) begin
            bad++;
            $display("FAIL count_15: got %0d want 15", miss_count);
        end
        for (int i = 0; i < 2; i++) begin
            do_miss(32'h300);
            total++;
            if (miss_count !== 4'd15) begin
                bad++;
                $display("FAIL count_sat%0d: got %0d want 15", i, miss_count);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_b = 1'b0; cache_en = 1'b0; mem_write = 1'b0; is_LB_SB = 1'b0;
        addr = '0; hit = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_load_hit();
        test_load_miss();
        test_store_hit();
        test_sb_miss();
        test_reset_mid_refill();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
